// File: rtl/regfile_arbiter.sv
// Two-master round-robin arbiter in front of a 32x32 register file.
// M1 may lock the file; read-during-write is served from a captured copy of the write data.
module regfile_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_m0_valid,
    output logic              o_m0_ready,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_raddr1,
    input  logic [ADDR_W-1:0] i_m0_raddr2,
    input  logic [ADDR_W-1:0] i_m0_waddr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata1,
    output logic [DATA_W-1:0] o_m0_rdata2,

    input  logic              i_m1_valid,
    output logic              o_m1_ready,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_raddr1,
    input  logic [ADDR_W-1:0] i_m1_raddr2,
    input  logic [ADDR_W-1:0] i_m1_waddr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata1,
    output logic [DATA_W-1:0] o_m1_rdata2,
    input  logic              i_m1_lock,

    output logic [ADDR_W-1:0] o_rf_raddr1,
    output logic [ADDR_W-1:0] o_rf_raddr2,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_rf_we,
    input  logic [DATA_W-1:0] i_rf_rdata1,
    input  logic [DATA_W-1:0] i_rf_rdata2,

    output logic              o_locked
);

    localparam int CNT_W = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {S_ARB, S_LOCK} state_t;

    state_t            state_q, state_d;
    logic              last_m1_q, last_m1_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic              byp1_q, byp1_d;
    logic              byp2_q, byp2_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    logic              grant_m0, grant_m1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_raddr1, sel_raddr2, sel_waddr;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_en;

    // No grant while reset is asserted, so a request in a reset cycle is never accepted.
    always_comb begin
        grant_m0 = 1'b0;
        grant_m1 = 1'b0;
        if (i_rst_n) begin
            if (state_q == S_LOCK) begin
                grant_m1 = i_m1_valid;
            end else if (i_m0_valid && i_m1_valid) begin
                grant_m0 = last_m1_q;
                grant_m1 = !last_m1_q;
            end else begin
                grant_m0 = i_m0_valid;
                grant_m1 = i_m1_valid;
            end
        end
    end

    assign o_m0_ready = grant_m0;
    assign o_m1_ready = grant_m1;

    always_comb begin
        sel_we     = 1'b0;
        sel_raddr1 = '0;
        sel_raddr2 = '0;
        sel_waddr  = '0;
        sel_wdata  = '0;
        if (grant_m0) begin
            sel_we     = i_m0_we;
            sel_raddr1 = i_m0_raddr1;
            sel_raddr2 = i_m0_raddr2;
            sel_waddr  = i_m0_waddr;
            sel_wdata  = i_m0_wdata;
        end else if (grant_m1) begin
            sel_we     = i_m1_we;
            sel_raddr1 = i_m1_raddr1;
            sel_raddr2 = i_m1_raddr2;
            sel_waddr  = i_m1_waddr;
            sel_wdata  = i_m1_wdata;
        end
    end

    assign wr_en       = sel_we && (sel_waddr != '0);
    assign o_rf_raddr1 = sel_raddr1;
    assign o_rf_raddr2 = sel_raddr2;
    assign o_rf_waddr  = sel_waddr;
    assign o_rf_wdata  = sel_wdata;
    assign o_rf_we     = wr_en;

    always_comb begin
        state_d     = state_q;
        last_m1_d   = last_m1_q;
        lock_cnt_d  = lock_cnt_q;
        if (grant_m0) last_m1_d = 1'b0;
        if (grant_m1) last_m1_d = 1'b1;
        case (state_q)
            S_ARB: begin
                lock_cnt_d = '0;
                if (grant_m1 && i_m1_lock) state_d = S_LOCK;
            end
            S_LOCK: begin
                if (!i_m1_lock) begin
                    state_d    = S_ARB;
                    lock_cnt_d = '0;
                end else if (grant_m1) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q >= CNT_LAST) begin
                    // Forced release hands the next tie to M0.
                    state_d    = S_ARB;
                    lock_cnt_d = '0;
                    last_m1_d  = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    // The register file returns stale data on read-during-write, so the write data is kept here.
    always_comb begin
        m0_rvalid_d = grant_m0;
        m1_rvalid_d = grant_m1;
        byp1_d      = wr_en && (sel_raddr1 == sel_waddr);
        byp2_d      = wr_en && (sel_raddr2 == sel_waddr);
        byp_data_d  = sel_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_ARB;
            last_m1_q   <= 1'b1;
            lock_cnt_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_m1_q   <= last_m1_d;
            lock_cnt_q  <= lock_cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            byp1_q      <= byp1_d;
            byp2_q      <= byp2_d;
            byp_data_q  <= byp_data_d;
        end
    end

    assign o_m0_rvalid = m0_rvalid_q;
    assign o_m1_rvalid = m1_rvalid_q;
    assign o_m0_rdata1 = m0_rvalid_q ? (byp1_q ? byp_data_q : i_rf_rdata1) : '0;
    assign o_m0_rdata2 = m0_rvalid_q ? (byp2_q ? byp_data_q : i_rf_rdata2) : '0;
    assign o_m1_rdata1 = m1_rvalid_q ? (byp1_q ? byp_data_q : i_rf_rdata1) : '0;
    assign o_m1_rdata2 = m1_rvalid_q ? (byp2_q ? byp_data_q : i_rf_rdata2) : '0;
    assign o_locked    = (state_q == S_LOCK);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a register-file stub, a request-level model checked every cycle,
// and directed scenarios with literal expectations.
module tb_regfile_arbiter;

    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } req_t;

    logic  clk = 1'b0;
    logic  rstN;
    req_t  m0Req, m1Req;
    logic  m1Lock;

    logic        m0Ready, m0Rvalid, m1Ready, m1Rvalid, rfWe, locked;
    logic [31:0] m0Rdata1, m0Rdata2, m1Rdata1, m1Rdata2, rfWdata, rfRdata1, rfRdata2;
    logic [4:0]  rfRaddr1, rfRaddr2, rfWaddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_W(5), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_m0_valid(m0Req.valid), .o_m0_ready(m0Ready), .i_m0_we(m0Req.we),
        .i_m0_raddr1(m0Req.raddr1), .i_m0_raddr2(m0Req.raddr2),
        .i_m0_waddr(m0Req.waddr), .i_m0_wdata(m0Req.wdata),
        .o_m0_rvalid(m0Rvalid), .o_m0_rdata1(m0Rdata1), .o_m0_rdata2(m0Rdata2),
        .i_m1_valid(m1Req.valid), .o_m1_ready(m1Ready), .i_m1_we(m1Req.we),
        .i_m1_raddr1(m1Req.raddr1), .i_m1_raddr2(m1Req.raddr2),
        .i_m1_waddr(m1Req.waddr), .i_m1_wdata(m1Req.wdata),
        .o_m1_rvalid(m1Rvalid), .o_m1_rdata1(m1Rdata1), .o_m1_rdata2(m1Rdata2),
        .i_m1_lock(m1Lock),
        .o_rf_raddr1(rfRaddr1), .o_rf_raddr2(rfRaddr2), .o_rf_waddr(rfWaddr),
        .o_rf_wdata(rfWdata), .o_rf_we(rfWe),
        .i_rf_rdata1(rfRdata1), .i_rf_rdata2(rfRdata2),
        .o_locked(locked)
    );

    function automatic logic [31:0] initVal(input int i);
        return (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
    endfunction

    function automatic req_t mkReq(input logic v, input logic we, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] wa, input logic [31:0] wd);
        req_t r;
        r.valid = v; r.we = we; r.raddr1 = r1; r.raddr2 = r2; r.waddr = wa; r.wdata = wd;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input req_t r0, input req_t r1, input logic lock);
        m0Req  = r0;
        m1Req  = r1;
        m1Lock = lock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register file stub: 1-cycle read latency, old data on read-during-write, r0 never written.
    logic [31:0] rfMem [32];
    always @(posedge clk) begin
        rfRdata1 <= rfMem[rfRaddr1];
        rfRdata2 <= rfMem[rfRaddr2];
        if (!rstN) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= initVal(i);
        end else if (rfWe && rfWaddr != 5'd0) begin
            rfMem[rfWaddr] <= rfWdata;
        end
    end

    // Request-level model: picks the winner from the rules, treats each accepted request as
    // "apply write, then read architectural registers", and checks the DUT every cycle.
    logic [31:0] arch [32];
    logic        mLocked, mLast, armed = 1'b0;
    int          mIdle;
    logic        pendV [2];
    logic [31:0] pendD1 [2];
    logic [31:0] pendD2 [2];

    always @(negedge clk) begin : modelStep
        int   g;
        req_t gr;
        logic expWe;
        g = -1;
        if (rstN === 1'b1) begin
            if (mLocked) begin
                if (m1Req.valid) g = 1;
            end else if (m0Req.valid && m1Req.valid) begin
                g = mLast ? 0 : 1;
            end else if (m0Req.valid) begin
                g = 0;
            end else if (m1Req.valid) begin
                g = 1;
            end
        end
        gr    = (g == 1) ? m1Req : ((g == 0) ? m0Req : '0);
        expWe = gr.we && (gr.waddr != 5'd0);
        if (armed) begin
            checkOutput("m0_ready", m0Ready, g == 0);
            checkOutput("m1_ready", m1Ready, g == 1);
            checkOutput("rf_we", rfWe, expWe);
            checkOutput("rf_raddr1", rfRaddr1, gr.raddr1);
            checkOutput("rf_raddr2", rfRaddr2, gr.raddr2);
            checkOutput("rf_waddr", rfWaddr, gr.waddr);
            checkOutput("rf_wdata", rfWdata, gr.wdata);
            checkOutput("locked", locked, mLocked);
            checkOutput("m0_rvalid", m0Rvalid, pendV[0]);
            checkOutput("m1_rvalid", m1Rvalid, pendV[1]);
            checkOutput("m0_rdata1", m0Rdata1, pendV[0] ? pendD1[0] : 32'h0);
            checkOutput("m0_rdata2", m0Rdata2, pendV[0] ? pendD2[0] : 32'h0);
            checkOutput("m1_rdata1", m1Rdata1, pendV[1] ? pendD1[1] : 32'h0);
            checkOutput("m1_rdata2", m1Rdata2, pendV[1] ? pendD2[1] : 32'h0);
        end
        if (rstN !== 1'b1) begin
            for (int i = 0; i < 32; i++) arch[i] = initVal(i);
            mLocked = 1'b0;
            mLast   = 1'b1;
            mIdle   = 0;
            for (int m = 0; m < 2; m++) begin
                pendV[m] = 1'b0; pendD1[m] = 32'h0; pendD2[m] = 32'h0;
            end
            armed = 1'b1;
        end else begin
            for (int m = 0; m < 2; m++) begin
                pendV[m] = 1'b0; pendD1[m] = 32'h0; pendD2[m] = 32'h0;
            end
            if (g >= 0) begin
                if (expWe) arch[gr.waddr] = gr.wdata;
                pendV[g]  = 1'b1;
                pendD1[g] = arch[gr.raddr1];
                pendD2[g] = arch[gr.raddr2];
                mLast     = (g == 1);
            end
            if (!mLocked) begin
                if (g == 1 && m1Lock) begin
                    mLocked = 1'b1;
                    mIdle   = 0;
                end
            end else if (!m1Lock) begin
                mLocked = 1'b0;
                mIdle   = 0;
            end else if (g == 1) begin
                mIdle = 0;
            end else if (mIdle == LOCK_MAX - 1) begin
                mLocked = 1'b0;
                mIdle   = 0;
                mLast   = 1'b1;
            end else begin
                mIdle++;
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int   zeros, firstGrant, cnt, m0Blocked;
        logic lockedAt16, lockedAt17;
        req_t m1Seq [3];

        rstN = 1'b0;
        applyStimulus('0, '0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_m0_rvalid", m0Rvalid, 1'b0);
        checkOutput("rst_m1_rvalid", m1Rvalid, 1'b0);
        checkOutput("rst_locked", locked, 1'b0);
        tick();
        rstN = 1'b1;

        // Continuous ties alternate starting with M0
        applyStimulus(mkReq(1, 0, 5'd1, 5'd2, 5'd0, 0), mkReq(1, 0, 5'd3, 5'd4, 5'd0, 0), 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("alt_m0_ready", m0Ready, (c % 2) == 0);
            checkOutput("alt_m1_ready", m1Ready, (c % 2) == 1);
            if (c == 1) checkOutput("alt_m0_rdata1", m0Rdata1, 32'hA000_0001);
            if (c == 2) checkOutput("alt_m1_rdata2", m1Rdata2, 32'hA000_0004);
            if (c > 0) checkOutput("alt_rvalid", (c % 2 == 1) ? m0Rvalid : m1Rvalid, 1'b1);
            tick();
        end

        // Write r5 with same-cycle read of r5 and r0
        applyStimulus(mkReq(1, 1, 5'd5, 5'd0, 5'd5, 32'hDEAD_BEEF), '0, 1'b0);
        @(negedge clk);
        checkOutput("byp_rf_we", rfWe, 1'b1);
        tick();
        applyStimulus('0, '0, 1'b0);
        @(negedge clk);
        checkOutput("byp_rvalid", m0Rvalid, 1'b1);
        checkOutput("byp_rdata1", m0Rdata1, 32'hDEAD_BEEF);
        checkOutput("byp_rdata2", m0Rdata2, 32'h0);
        tick();
        applyStimulus(mkReq(1, 0, 5'd5, 5'd5, 5'd0, 0), '0, 1'b0);
        tick();
        applyStimulus('0, '0, 1'b0);
        @(negedge clk);
        checkOutput("r5_readback", m0Rdata1, 32'hDEAD_BEEF);
        tick();

        // Write to r0 is blocked and never bypassed
        applyStimulus(mkReq(1, 1, 5'd0, 5'd0, 5'd0, 32'h1234_5678), '0, 1'b0);
        @(negedge clk);
        checkOutput("r0_rf_we", rfWe, 1'b0);
        tick();
        applyStimulus('0, '0, 1'b0);
        @(negedge clk);
        checkOutput("r0_rdata1", m0Rdata1, 32'h0);
        tick();

        // Lock then idle: timeout release after LOCK_MAX idle cycles
        applyStimulus(mkReq(1, 0, 5'd1, 5'd2, 5'd0, 0), mkReq(1, 0, 5'd3, 5'd4, 5'd0, 0), 1'b1);
        @(negedge clk);
        checkOutput("lock_m1_ready", m1Ready, 1'b1);
        tick();
        applyStimulus(mkReq(1, 0, 5'd1, 5'd2, 5'd0, 0), '0, 1'b1);
        zeros = 0; firstGrant = -1; lockedAt16 = 1'b0; lockedAt17 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (firstGrant < 0) begin
                if (m0Ready) firstGrant = k;
                else zeros++;
            end
            if (k == 16) lockedAt16 = locked;
            if (k == 17) lockedAt17 = locked;
            tick();
        end
        checkOutput("to_m0_blocked", zeros, 16);
        checkOutput("to_first_m0", firstGrant, 17);
        checkOutput("to_locked_16", lockedAt16, 1'b1);
        checkOutput("to_locked_17", lockedAt17, 1'b0);
        applyStimulus('0, '0, 1'b0);
        tick();

        // Locked burst of three M1 requests, then lock dropped while M0 waits
        m1Seq[0] = mkReq(1, 0, 5'd3, 5'd3, 5'd0, 0);
        m1Seq[1] = mkReq(1, 1, 5'd0, 5'd0, 5'd7, 32'h77);
        m1Seq[2] = mkReq(1, 0, 5'd7, 5'd0, 5'd0, 0);
        cnt = 0; m0Blocked = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkReq(1, 0, 5'd1, 5'd1, 5'd0, 0), m1Seq[k], 1'b1);
            @(negedge clk);
            if (m1Ready) cnt++;
            if (!m0Ready) m0Blocked++;
            if (k > 0) checkOutput("burst_m1_rvalid", m1Rvalid, 1'b1);
            tick();
        end
        checkOutput("burst_m1_grants", cnt, 3);
        applyStimulus(mkReq(1, 0, 5'd1, 5'd1, 5'd0, 0), '0, 1'b0);
        @(negedge clk);
        if (!m0Ready) m0Blocked++;
        checkOutput("burst_m1_rvalid3", m1Rvalid, 1'b1);
        checkOutput("burst_rdata_r7", m1Rdata1, 32'h0000_0077);
        tick();
        checkOutput("burst_m0_blocked", m0Blocked, 4);
        @(negedge clk);
        checkOutput("burst_m0_after", m0Ready, 1'b1);
        tick();

        // Reset right after an M0 handshake, with a locking M1 request in the reset cycle
        applyStimulus(mkReq(1, 0, 5'd2, 5'd3, 5'd0, 0), '0, 1'b0);
        @(negedge clk);
        checkOutput("rr_m0_ready", m0Ready, 1'b1);
        tick();
        rstN = 1'b0;
        applyStimulus(mkReq(1, 0, 5'd2, 5'd3, 5'd0, 0), mkReq(1, 0, 5'd4, 5'd5, 5'd0, 0), 1'b1);
        @(negedge clk);
        checkOutput("rr_m1_ready_in_rst", m1Ready, 1'b0);
        checkOutput("rr_m0_ready_in_rst", m0Ready, 1'b0);
        tick();
        rstN = 1'b1;
        applyStimulus(mkReq(1, 0, 5'd2, 5'd3, 5'd0, 0), mkReq(1, 0, 5'd4, 5'd5, 5'd0, 0), 1'b0);
        @(negedge clk);
        checkOutput("rr_m0_rvalid", m0Rvalid, 1'b0);
        checkOutput("rr_locked", locked, 1'b0);
        checkOutput("rr_tie_m0", m0Ready, 1'b1);
        checkOutput("rr_tie_m1", m1Ready, 1'b0);
        tick();
        applyStimulus('0, '0, 1'b0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
